iter_muldiv: RTL and testbench

Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake. It iterates radix-2 (one bit per cycle) for a fixed latency and returns a result with flags and the caller's tag. It is width-parametrised so the same block serves the 16-bit core and wider derivatives.

---
 rtl/iter_muldiv.sv | 176 +++++++++++++++++
 tb/tb_iter_muldiv.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv.sv
// Radix-2 iterative multiply/divide unit: one request at a time, fixed
// WIDTH+1 cycle latency, result held until the consumer takes it.
module iter_muldiv #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               sign_q, sign_d;
    logic               dz_pend_q, dz_pend_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0]   opa_q, opa_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod_q, prod_d;    // product, or {remainder, quotient}
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;

    logic               neg_a, neg_b, sign_in, dz_in, ovf_in, sgn_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, sel_res;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

    // Operand conditioning at accept: magnitudes, result sign, special-case flags.
    always_comb begin
        sgn_op  = (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
        neg_a   = sgn_op && a[WIDTH-1];
        neg_b   = sgn_op && b[WIDTH-1];
        mag_a   = a;
        mag_b   = b;
        if (neg_a) mag_a = -a;   // most-negative maps onto 2^(WIDTH-1) unsigned
        if (neg_b) mag_b = -b;
        sign_in = (op == 3'b111) ? neg_a : (neg_a ^ neg_b);
        dz_in   = op[2] && (b == '0);
        ovf_in  = op[2] && op[1] && (a == MIN_NEG) && (b == '1);
    end

    // One iteration step and the final sign-corrected result selection.
    always_comb begin
        // shift-add: conditionally add multiplicand to upper half, shift right
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
        mul_step  = {mul_sum, prod_q[WIDTH-1:1]};
        // restoring divide: trial-subtract divisor from shifted partial remainder
        div_trial = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, opa_q};
        if (!div_trial[WIDTH])
            div_step = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else
            div_step = {prod_q[2*WIDTH-2:0], 1'b0};

        prod_fix = sign_q ? -prod_q : prod_q;
        quo_fix  = sign_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix  = sign_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

        case (op_q)
            3'b001:         sel_res = prod_q[2*WIDTH-1:WIDTH];
            3'b010:         sel_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b110: sel_res = dz_pend_q ? '1 : (ovf_pend_q ? MIN_NEG : quo_fix);
            // with b == 0 the iteration leaves |a| as remainder, so rem_fix == a
            3'b101, 3'b111: sel_res = ovf_pend_q ? '0 : rem_fix;
            default:        sel_res = prod_fix[WIDTH-1:0];   // MULL and reserved 011
        endcase
    end

    // Next-state and register updates; flush overrides everything else.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        sign_d     = sign_q;
        dz_pend_d  = dz_pend_q;
        ovf_pend_d = ovf_pend_q;
        opa_d      = opa_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        out_tag_d  = out_tag_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d    = BUSY;
                op_d       = op;
                tag_d      = tag;
                sign_d     = sign_in;
                dz_pend_d  = dz_in;
                ovf_pend_d = ovf_in;
                opa_d      = op[2] ? mag_b : mag_a;
                prod_d     = {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
                cnt_d      = CW'(WIDTH);
            end
            BUSY: if (cnt_q != '0) begin
                prod_d = op_q[2] ? div_step : mul_step;
                cnt_d  = cnt_q - CW'(1);
            end else begin
                state_d    = DONE;
                result_d   = sel_res;
                out_tag_d  = tag_q;
                div_zero_d = dz_pend_q;
                ovf_d      = ovf_pend_q;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            result_d   = result_q;
            out_tag_d  = out_tag_q;
            div_zero_d = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    // State register, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            tag_q      <= '0;
            sign_q     <= 1'b0;
            dz_pend_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            opa_q      <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            out_tag_q  <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            sign_q     <= sign_d;
            dz_pend_q  <= dz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            opa_q      <= opa_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            out_tag_q  <= out_tag_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv at WIDTH=16: arithmetic vectors, special
// cases, backpressure, flush and mid-operation reset.
module tb_iter_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [2:0]  out_tag;
    logic        div_zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    iter_muldiv #(.WIDTH(16), .TAG_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Count edges until out_valid, bounded so a dead unit cannot hang the run.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic quiet(input string nm, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk(nm, seen, 0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [2:0] tg);
        op = o; a = aa; b = bb; tag = tg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [2:0] tg, input logic [15:0] er,
                          input logic edz, input logic eovf);
        int n;
        chk({nm, "_idle_rdy"}, in_ready, 1);
        issue(o, aa, bb, tg);
        chk({nm, "_busy_rdy"}, in_ready, 0);
        wait_valid(n);
        chk({nm, "_lat"}, n, 17);
        chk({nm, "_res"}, result, er);
        chk({nm, "_tag"}, out_tag, tg);
        chk({nm, "_dz"}, div_zero, edz);
        chk({nm, "_ovf"}, ovf, eovf);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_post_rdy"}, in_ready, 1);
        chk({nm, "_post_vld"}, out_valid, 0);
    endtask

    initial begin
        int n;
        #22;
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_res", result, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("mull",   3'b000, 16'h1234, 16'h0010, 3'd5, 16'h2340, 0, 0);
        run_op("mulhu",  3'b001, 16'h1234, 16'h0010, 3'd5, 16'h0001, 0, 0);
        run_op("mulhs",  3'b010, 16'hFFFF, 16'h0002, 3'd1, 16'hFFFF, 0, 0);
        run_op("mull_n", 3'b000, 16'hFFFF, 16'h0002, 3'd2, 16'hFFFE, 0, 0);
        run_op("mulhs_mn", 3'b010, 16'h8000, 16'h8000, 3'd3, 16'h4000, 0, 0);
        run_op("resv",   3'b011, 16'h1234, 16'h0010, 3'd4, 16'h2340, 0, 0);
        run_op("divs",   3'b110, 16'hFFF9, 16'h0002, 3'd6, 16'hFFFD, 0, 0);
        run_op("rems",   3'b111, 16'hFFF9, 16'h0002, 3'd7, 16'hFFFF, 0, 0);
        run_op("divs_nb", 3'b110, 16'h0007, 16'hFFFE, 3'd1, 16'hFFFD, 0, 0);
        run_op("rems_nb", 3'b111, 16'h0007, 16'hFFFE, 3'd2, 16'h0001, 0, 0);
        run_op("divu",   3'b100, 16'h0064, 16'h0007, 3'd3, 16'h000E, 0, 0);
        run_op("remu",   3'b101, 16'h0064, 16'h0007, 3'd4, 16'h0002, 0, 0);
        run_op("divu_z", 3'b100, 16'h1234, 16'h0000, 3'd5, 16'hFFFF, 1, 0);
        run_op("remu_z", 3'b101, 16'h1234, 16'h0000, 3'd6, 16'h1234, 1, 0);
        run_op("rems_z", 3'b111, 16'hFFF9, 16'h0000, 3'd7, 16'hFFF9, 1, 0);
        run_op("divs_o", 3'b110, 16'h8000, 16'hFFFF, 3'd1, 16'h8000, 0, 1);
        run_op("rems_o", 3'b111, 16'h8000, 16'hFFFF, 3'd2, 16'h0000, 0, 1);

        // Backpressure: response held, a second request waits past the handshake.
        issue(3'b000, 16'h1234, 16'h0003, 3'd6);
        wait_valid(n);
        chk("bp_lat", n, 17);
        op = 3'b100; a = 16'h0064; b = 16'h0007; tag = 3'd2; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_res", result, 16'h369C);
            chk("bp_tag", out_tag, 6);
            chk("bp_rdy", in_ready, 0);
            chk("bp_vld", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_no_same_accept", in_ready, 1);
        chk("bp_hs_vld", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept2", in_ready, 0);
        wait_valid(n);
        chk("bp2_lat", n, 17);
        chk("bp2_res", result, 16'h000E);
        chk("bp2_tag", out_tag, 2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Flush during the 7th BUSY cycle.
        issue(3'b000, 16'h0101, 16'h0002, 3'd3);
        repeat (6) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_rdy", in_ready, 1);
        chk("fl_vld", out_valid, 0);
        chk("fl_res_kept", result, 16'h000E);
        quiet("fl_quiet", 25);
        run_op("fl_after", 3'b101, 16'h0064, 16'h000A, 3'd4, 16'h0000, 0, 0);

        // Flush in DONE beats a simultaneous handshake and clears flags.
        issue(3'b100, 16'h0005, 16'h0000, 3'd5);
        wait_valid(n);
        chk("fd_dz_before", div_zero, 1);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("fd_vld", out_valid, 0);
        chk("fd_dz", div_zero, 0);
        chk("fd_res_kept", result, 16'hFFFF);

        // Asynchronous reset mid-BUSY.
        issue(3'b000, 16'h0003, 16'h0003, 3'd7);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("ar_rdy", in_ready, 1);
        chk("ar_vld", out_valid, 0);
        chk("ar_res", result, 0);
        chk("ar_tag", out_tag, 0);
        chk("ar_dz", div_zero, 0);
        #3 rst = 1'b1;
        quiet("ar_quiet", 25);
        run_op("ar_after", 3'b000, 16'h0003, 16'h0003, 3'd7, 16'h0009, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
